// File: rtl/lpc_autocorr.sv
// rtl/lpc_autocorr.sv - frame-local autocorrelation r[0..ORDER] for LPC analysis
// One shared MAC walks the lags for each fetched sample; results stream out over valid/ready.
module lpc_autocorr #(
  parameter int FIFO_ADDR_WIDTH = 10,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int SAMPLE_WIDTH    = 16,
  parameter int FRAME_LEN       = 80,
  parameter int ORDER           = 10,
  parameter int ACC_WIDTH       = 40
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       sys_ce,
  input  logic [FIFO_ADDR_WIDTH-1:0] aff_data_count,
  input  logic                       aff_data_empty,
  input  logic [FIFO_DATA_WIDTH-1:0] aff_read_data,
  output logic                       lsp_read_en,
  output logic [ACC_WIDTH-1:0]       acf_coef,
  output logic [3:0]                 acf_coef_idx,
  output logic                       acf_coef_valid,
  input  logic                       acf_coef_ready,
  output logic                       acf_frame_done,
  output logic                       acf_busy
);

  localparam int N_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [N_W-1:0]             N_LAST    = N_W'(FRAME_LEN - 1);
  localparam logic [3:0]                 K_LAST    = 4'(ORDER);
  localparam logic [FIFO_ADDR_WIDTH-1:0] FRAME_CNT = FIFO_ADDR_WIDTH'(FRAME_LEN);
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, MAC, OUT} state_t;

  state_t                         state;
  logic signed [SAMPLE_WIDTH-1:0] hist [0:ORDER];
  logic signed [ACC_WIDTH-1:0]    acc  [0:ORDER];
  logic [N_W-1:0]                 n_cnt;
  logic [3:0]                     k_cnt;

  logic signed [SAMPLE_WIDTH-1:0]   sample;
  logic signed [2*SAMPLE_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH:0]        sum_wide;
  logic signed [ACC_WIDTH-1:0]      acc_sat;
  logic                             unused_upper;

  assign sample       = signed'(aff_read_data[SAMPLE_WIDTH-1:0]);
  assign unused_upper = ^aff_read_data[FIFO_DATA_WIDTH-1:SAMPLE_WIDTH];

  // The pop must never outlive the FETCH cycle, so it is gated rather than registered.
  assign lsp_read_en = sys_rst_n && sys_ce && (state == FETCH) && !aff_data_empty;
  assign acf_busy    = (state != IDLE);

  always_comb begin
    prod     = hist[0] * hist[k_cnt];
    sum_wide = (ACC_WIDTH+1)'(acc[k_cnt]) + (ACC_WIDTH+1)'(prod);
    if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1])
      acc_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    else
      acc_sat = sum_wide[ACC_WIDTH-1:0];
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state <= IDLE;
      for (int i = 0; i <= ORDER; i++) begin
        hist[i] <= '0;
        acc[i]  <= '0;
      end
      n_cnt          <= '0;
      k_cnt          <= '0;
      acf_coef       <= '0;
      acf_coef_idx   <= '0;
      acf_coef_valid <= 1'b0;
      acf_frame_done <= 1'b0;
    end else if (sys_ce) begin
      acf_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          for (int i = 0; i <= ORDER; i++) begin
            hist[i] <= '0;
            acc[i]  <= '0;
          end
          n_cnt <= '0;
          if (aff_data_count >= FRAME_CNT)
            state <= FETCH;
        end

        FETCH: begin
          if (!aff_data_empty) begin
            hist[0] <= sample;
            for (int i = 1; i <= ORDER; i++)
              hist[i] <= hist[i-1];
            k_cnt <= '0;
            state <= MAC;
          end
        end

        MAC: begin
          acc[k_cnt] <= acc_sat;
          if (k_cnt == K_LAST) begin
            k_cnt <= '0;
            if (n_cnt == N_LAST) begin
              // acc[0] is final by now; only the top lag is still being written.
              acf_coef       <= acc[0];
              acf_coef_idx   <= '0;
              acf_coef_valid <= 1'b1;
              state          <= OUT;
            end else begin
              n_cnt <= n_cnt + 1'b1;
              state <= FETCH;
            end
          end else begin
            k_cnt <= k_cnt + 1'b1;
          end
        end

        OUT: begin
          if (acf_coef_ready) begin
            if (acf_coef_idx == K_LAST) begin
              acf_coef_valid <= 1'b0;
              acf_frame_done <= 1'b1;
              acf_coef_idx   <= '0;
              state          <= IDLE;
            end else begin
              acf_coef_idx <= acf_coef_idx + 4'd1;
              acf_coef     <= acc[acf_coef_idx + 4'd1];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_autocorr.sv
// tb/tb_lpc_autocorr.sv - scoreboard bench for lpc_autocorr with a FWFT FIFO model
// Expected coefficients come from a direct sum over each frame's samples.
module tb_lpc_autocorr;
  localparam int AW = 10, DW = 32, SW = 16, FL = 80, ORD = 10, ACW = 40;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic          sys_ce = 1'b1;
  logic [AW-1:0] aff_data_count;
  logic          aff_data_empty;
  logic [DW-1:0] aff_read_data;
  logic          lsp_read_en;
  logic [ACW-1:0] acf_coef;
  logic [3:0]    acf_coef_idx;
  logic          acf_coef_valid;
  logic          acf_coef_ready = 1'b1;
  logic          acf_frame_done;
  logic          acf_busy;

  always #5 sys_clk = ~sys_clk;

  lpc_autocorr dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .sys_ce(sys_ce),
    .aff_data_count(aff_data_count), .aff_data_empty(aff_data_empty),
    .aff_read_data(aff_read_data), .lsp_read_en(lsp_read_en),
    .acf_coef(acf_coef), .acf_coef_idx(acf_coef_idx),
    .acf_coef_valid(acf_coef_valid), .acf_coef_ready(acf_coef_ready),
    .acf_frame_done(acf_frame_done), .acf_busy(acf_busy)
  );

  logic [DW-1:0] mem [0:4095];
  int   wp = 0, rp = 0, bias = 0;
  logic fifo_flush = 1'b0;
  assign aff_data_count = AW'(wp - rp + bias);
  assign aff_data_empty = (wp == rp);
  assign aff_read_data  = mem[rp[11:0]];

  int cyc = 0, pops = 0, dones = 0, last_pop_cyc = 0, done_cyc = 0;
  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (fifo_flush) rp <= wp;
    else if (lsp_read_en) begin
      rp <= rp + 1;
      pops <= pops + 1;
      last_pop_cyc <= cyc;
    end
    if (acf_frame_done) begin
      dones <= dones + 1;
      done_cyc <= cyc;
    end
  end

  int tests = 0, fails = 0;
  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct { int idx; longint val; } exp_t;
  exp_t exp_q[$];
  int   frame_buf [0:FL-1];

  task automatic model_push();
    longint r, lim;
    lim = longint'(1) << (ACW - 1);
    for (int k = 0; k <= ORD; k++) begin
      r = 0;
      for (int n = k; n < FL; n++)
        r += longint'(frame_buf[n]) * longint'(frame_buf[n-k]);
      if (r > lim - 1) r = lim - 1;
      if (r < -lim) r = -lim;
      exp_q.push_back('{k, r});
    end
  endtask

  task automatic push_word(input int i, input logic [15:0] upper);
    logic [15:0] s16;
    s16 = 16'(frame_buf[i]);
    mem[wp[11:0]] = {upper, s16};
    wp++;
  endtask

  task automatic push_range(input int lo, input int hi, input bit ones);
    for (int i = lo; i < hi; i++)
      push_word(i, ones ? 16'hFFFF : 16'($urandom));
  endtask

  int ready_mode = 0, hold = 0;
  initial forever begin
    @(negedge sys_clk);
    case (ready_mode)
      1: acf_coef_ready = ($urandom_range(0, 3) != 0);
      2: if (acf_coef_valid && acf_coef_idx == 4'd3 && hold < 5) begin
           acf_coef_ready = 1'b0;
           hold++;
         end else acf_coef_ready = 1'b1;
      default: acf_coef_ready = 1'b1;
    endcase
  end

  // Monitor: runs after the negedge drivers, so it sees what the next posedge will sample.
  logic            prev_stall = 1'b0;
  logic [ACW-1:0]  prev_coef;
  logic [3:0]      prev_idx;
  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    #1;
    if (!sys_rst_n) prev_stall = 1'b0;
    else begin
      if (lsp_read_en && aff_data_empty) check("pop_while_empty", 1, 0);
      if (!sys_ce && lsp_read_en) check("pop_while_ce_low", 1, 0);
      if (prev_stall) begin
        check("hold_coef", longint'(acf_coef), longint'(prev_coef));
        check("hold_idx", longint'(acf_coef_idx), longint'(prev_idx));
      end
      if (acf_coef_valid && acf_coef_ready && sys_ce) begin
        if (exp_q.size() == 0) check("unexpected_coef", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("coef_idx", longint'(acf_coef_idx), longint'(e.idx));
          check("coef_val", longint'(signed'(acf_coef)), e.val);
        end
      end
      prev_stall = acf_coef_valid && !(acf_coef_ready && sys_ce);
      prev_coef  = acf_coef;
      prev_idx   = acf_coef_idx;
    end
  end

  task automatic wait_pops(input int target, input string name);
    int c = 0;
    while (pops < target && c < 3000) begin @(negedge sys_clk); c++; end
    if (pops < target) check(name, pops, target);
  endtask

  task automatic wait_done(input int base_d, input int base_p, input string name);
    int c = 0;
    while (dones == base_d && c < 4000) begin @(negedge sys_clk); c++; end
    check({name, "_done"}, dones - base_d, 1);
    check({name, "_pops"}, pops - base_p, FL);
  endtask

  task automatic run_frame(input string name, input bit ones);
    int bd, bp;
    bd = dones; bp = pops;
    model_push();
    push_range(0, FL, ones);
    wait_done(bd, bp, name);
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic fill(input int kind);
    for (int i = 0; i < FL; i++)
      case (kind)
        0: frame_buf[i] = 100;
        1: frame_buf[i] = (i == 0) ? 1000 : 0;
        2: frame_buf[i] = (i % 2 == 0) ? 256 : -256;
        3: frame_buf[i] = -32768;
        default: frame_buf[i] = $urandom_range(0, 65535) - 32768;
      endcase
  endtask

  initial begin
    #1000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int bd, bp, t0, viol;
    repeat (3) @(negedge sys_clk);
    #1;
    check("rst_valid", acf_coef_valid, 0);
    check("rst_coef", longint'(acf_coef), 0);
    check("rst_idx", acf_coef_idx, 0);
    check("rst_done", acf_frame_done, 0);
    check("rst_busy", acf_busy, 0);
    check("rst_rd", lsp_read_en, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Constant +100 with timing check on an always-full FIFO.
    fill(0);
    bd = dones; bp = pops;
    model_push();
    push_range(0, FL, 0);
    wait_pops(bp + 1, "first_pop");
    t0 = last_pop_cyc;
    wait_done(bd, bp, "const100");
    check("frame_latency", done_cyc - t0, FL * (ORD + 2) + ORD + 1);
    repeat (3) @(negedge sys_clk);

    fill(1); run_frame("impulse", 0);
    fill(2); run_frame("alternating", 0);

    // 79 samples must not start a frame; upper bits all ones.
    fill(4);
    bd = dones; bp = pops;
    model_push();
    push_range(0, FL - 1, 1);
    viol = 0;
    repeat (200) begin
      @(negedge sys_clk); #1;
      if (lsp_read_en || acf_busy) viol++;
    end
    check("preload79_idle", viol, 0);
    push_range(FL - 1, FL, 1);
    wait_done(bd, bp, "preload80");
    repeat (3) @(negedge sys_clk);

    // Full-scale negative samples with back-pressure at idx 3.
    fill(3);
    hold = 0; ready_mode = 2;
    run_frame("neg_fullscale", 0);
    check("stall_applied", hold, 5);

    ready_mode = 1;
    for (int f = 0; f < 2; f++) begin
      fill(4); run_frame("random", 0);
    end
    ready_mode = 0;

    // Writer stall: count reports a full frame but only half is present.
    fill(4);
    bd = dones; bp = pops;
    model_push();
    bias = FL / 2;
    push_range(0, FL / 2, 0);
    wait_pops(bp + FL / 2, "half_pops");
    repeat (30) @(negedge sys_clk);
    check("stalled_pops", pops - bp, FL / 2);
    bias = 0;
    push_range(FL / 2, FL, 0);
    wait_done(bd, bp, "fifo_stall");
    repeat (3) @(negedge sys_clk);

    // Reset mid-MAC discards the frame.
    fill(0);
    bp = pops;
    push_range(0, FL, 0);
    wait_pops(bp + 10, "pre_reset_pops");
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0; fifo_flush = 1'b1;
    @(negedge sys_clk);
    sys_rst_n = 1'b1; fifo_flush = 1'b0;
    #1;
    check("mid_rst_valid", acf_coef_valid, 0);
    check("mid_rst_coef", longint'(acf_coef), 0);
    check("mid_rst_idx", acf_coef_idx, 0);
    check("mid_rst_busy", acf_busy, 0);
    check("mid_rst_rd", lsp_read_en, 0);
    repeat (2) @(negedge sys_clk);
    fill(0); run_frame("after_reset", 0);

    // Clock enable low for 10 cycles mid-frame delays completion by 10.
    fill(4);
    bd = dones; bp = pops;
    model_push();
    push_range(0, FL, 0);
    wait_pops(bp + 1, "ce_first_pop");
    t0 = last_pop_cyc;
    wait_pops(bp + 20, "ce_mid_pops");
    sys_ce = 1'b0;
    repeat (10) @(negedge sys_clk);
    sys_ce = 1'b1;
    wait_done(bd, bp, "ce_frame");
    check("ce_latency", done_cyc - t0, FL * (ORD + 2) + ORD + 1 + 10);
    repeat (3) @(negedge sys_clk);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lpc_autocorr.md
Name: lpc_autocorr

Overview:
- Consumes audio samples buffered by the async sample FIFO (the FIFO that sits after the high pass filter) and computes frame-local autocorrelation coefficients r[0..ORDER] for LPC analysis.
- Feeds the Levinson-Durbin stage through a valid/ready coefficient stream.
- Uses a single shared multiply-accumulate unit, sequenced by an FSM.

Parameters:
- FIFO_ADDR_WIDTH, 10, width of the FIFO data count.
- FIFO_DATA_WIDTH, 32, width of the FIFO read data.
- SAMPLE_WIDTH, 16, signed sample width taken from the FIFO word LSBs.
- FRAME_LEN, 80, samples per analysis frame.
- ORDER, 10, highest lag computed.
- ACC_WIDTH, 40, signed accumulator and coefficient width.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, synchronous, active-low.
- sys_ce  in  1  clock enable; 0 freezes all state.
- aff_data_count  in  FIFO_ADDR_WIDTH  FIFO occupancy.
- aff_data_empty  in  1  FIFO empty flag.
- aff_read_data  in  FIFO_DATA_WIDTH  FIFO head word (first-word-fall-through).
- lsp_read_en  out  1  FIFO pop strobe.
- acf_coef  out  ACC_WIDTH  coefficient r[acf_coef_idx], signed.
- acf_coef_idx  out  4  lag index 0..ORDER.
- acf_coef_valid  out  1  coefficient valid.
- acf_coef_ready  in  1  downstream accepts the coefficient.
- acf_frame_done  out  1  one-cycle pulse when the last coefficient is accepted.
- acf_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sys_rst_n=0 at a sys_clk edge):
  - State goes to IDLE.
  - History registers, accumulators, sample counter and lag counter clear to 0.
  - All outputs are 0.
  - Reset applies in any state; samples already popped from the FIFO are discarded.
- sys_ce=0: no state changes; lsp_read_en is forced to 0; all other outputs hold.
- FIFO is first-word-fall-through: aff_read_data is the head word whenever aff_data_empty=0. The sample is captured in the same cycle lsp_read_en=1; the FIFO advances on the next edge.
- Sample = signed aff_read_data[SAMPLE_WIDTH-1:0]; upper bits are ignored.
- History: hist[0..ORDER], where hist[0] is the newest sample. Each fetch shifts hist[i] into hist[i+1] and loads the new sample into hist[0]. hist is zeroed at frame start, so x[n-k] for n<k contributes 0 (no carry-over between frames).
- States:
  - IDLE:
    - Clear accumulators, hist and the sample counter n.
    - Go to FETCH when aff_data_count >= FRAME_LEN.
  - FETCH:
    - If aff_data_empty=0: lsp_read_en=1 for exactly this cycle, shift the sample in, set k=0, go to MAC.
    - Otherwise wait with lsp_read_en=0.
  - MAC:
    - Runs ORDER+1 cycles, k=0..ORDER.
    - Each cycle: acc[k] <= sat(acc[k] + hist[0]*hist[k]), using a 2*SAMPLE_WIDTH signed product sign-extended to ACC_WIDTH.
    - At k=ORDER: if n=FRAME_LEN-1, go to OUT with idx=0; otherwise increment n and go to FETCH.
  - OUT:
    - acf_coef_valid=1, acf_coef=acc[idx], acf_coef_idx=idx.
    - The output is held stable until acf_coef_ready=1, then idx increments.
    - On acceptance at idx=ORDER: acf_frame_done=1 for that cycle, valid drops, go to IDLE.
- Saturation: a sum above 2^(ACC_WIDTH-1)-1 clamps to that value; a sum below -2^(ACC_WIDTH-1) clamps to that value. With the default parameters no overflow is possible.
- Timing:
  - Exactly FRAME_LEN pops per frame; lsp_read_en is never asserted while aff_data_empty=1.
  - Per-frame compute time is FRAME_LEN*(ORDER+2) cycles (960 with defaults) when the FIFO never empties; add 1 cycle per coefficient in OUT at ready=1.
  - After acf_frame_done, a new frame starts no earlier than 1 IDLE cycle later.
- Boundaries:
  - If the FIFO empties mid-frame (writer stalled), FETCH stalls and the result is unaffected.
  - If aff_data_count >= FRAME_LEN while OUT is back-pressured, no pop occurs until the module returns to IDLE.

Test Plan:
- 80 samples of +100, ready=1 -> r[k]=10000*(80-k): r0=800000, r1=790000, r10=700000; exactly 80 lsp_read_en pulses; acf_frame_done asserted once.
- Impulse: sample0=1000, samples 1..79=0 -> r0=1000000, r1..r10=0.
- Alternating +256/-256 -> r[k]=65536*(80-k)*(-1)^k: r0=5242880, r1=-5177344, r2=5111808.
- Preload 79 samples -> no lsp_read_en and acf_busy=0 for 200 cycles; write the 80th -> FETCH starts, frame completes; upper FIFO bits set to 0xFFFF are ignored.
- 80 samples of -32768 -> r0=85899345920 with no saturation. Hold ready=0 for 5 cycles at idx=3 -> acf_coef and idx stay stable, no index skipped.
- Assert sys_rst_n=0 for 1 cycle mid-MAC -> next cycle all outputs 0 and state IDLE; the following frame of +100 samples yields the test-1 values. sys_ce=0 for 10 cycles mid-frame -> identical results, with the frame delayed by 10 cycles.
